// File: rtl/id_ex_stage_reg.sv
// Decode-to-Execute pipeline register with stall, flush-to-bubble, valid tracking
// and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic [2:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ByteAccessD,
    input  logic [3:0]       ALUControlD,
    input  logic [2:0]       ByteSrcD,
    input  logic             PredTakenD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    output logic             ValidE,
    output logic             RegWriteE,
    output logic [2:0]       ResultSrcE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ByteAccessE,
    output logic [3:0]       ALUControlE,
    output logic [2:0]       ByteSrcE,
    output logic             PredTakenE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [CNT_W-1:0] BubbleCnt
);

    // A flushed slot is cleared completely so a bubble looks exactly like reset state,
    // including zeroed register indices that can never match a forwarding source.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || FlushE) begin
            if (!reset_n || FlushE) begin
                ValidE      <= 1'b0;
                RegWriteE   <= 1'b0;
                ResultSrcE  <= '0;
                MemWriteE   <= 1'b0;
                JumpE       <= 1'b0;
                BranchE     <= 1'b0;
                ALUSrcE     <= 1'b0;
                ByteAccessE <= '0;
                ALUControlE <= '0;
                ByteSrcE    <= '0;
                PredTakenE  <= 1'b0;
                RD1E        <= '0;
                RD2E        <= '0;
                PCE         <= '0;
                PCPlus4E    <= '0;
                ImmExtE     <= '0;
                Rs1E        <= '0;
                Rs2E        <= '0;
                RdE         <= '0;
            end
        end else if (!StallE) begin
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD;
            ResultSrcE  <= ResultSrcD;
            MemWriteE   <= MemWriteD;
            JumpE       <= JumpD;
            BranchE     <= BranchD;
            ALUSrcE     <= ALUSrcD;
            ByteAccessE <= ByteAccessD;
            ALUControlE <= ALUControlD;
            ByteSrcE    <= ByteSrcD;
            PredTakenE  <= PredTakenD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            ImmExtE     <= ImmExtD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
        end
    end

    // Bubble counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            BubbleCnt <= '0;
        end else if (FlushE && (BubbleCnt != {CNT_W{1'b1}})) begin
            BubbleCnt <= BubbleCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (4-bit bubble counter so saturation is reachable).
module tb_id_ex_stage_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             StallE, FlushE, ValidD;
    logic             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, PredTakenD;
    logic [2:0]       ResultSrcD, ByteSrcD;
    logic [1:0]       ByteAccessD;
    logic [3:0]       ALUControlD;
    logic [XLEN-1:0]  RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]       Rs1D, Rs2D, RdD;
    logic             ValidE;
    logic             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, PredTakenE;
    logic [2:0]       ResultSrcE, ByteSrcE;
    logic [1:0]       ByteAccessE;
    logic [3:0]       ALUControlE;
    logic [XLEN-1:0]  RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [CNT_W-1:0] BubbleCnt;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] expCnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ByteAccessD(ByteAccessD), .ALUControlD(ALUControlD),
        .ByteSrcD(ByteSrcD), .PredTakenD(PredTakenD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ByteAccessE(ByteAccessE),
        .ALUControlE(ALUControlE), .ByteSrcE(ByteSrcE), .PredTakenE(PredTakenE), .RD1E(RD1E),
        .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .BubbleCnt(BubbleCnt)
    );

    // Pipeline payload (everything except ValidE and BubbleCnt), gathered for bulk checks.
    wire [194:0] payloadE = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
                             ByteAccessE, ALUControlE, ByteSrcE, PredTakenE, RD1E, RD2E,
                             PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};
    wire [194:0] payloadD = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
                             ByteAccessD, ALUControlD, ByteSrcD, PredTakenD, RD1D, RD2D,
                             PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pattern(input logic [31:0] base);
        ValidD      = 1'b1;
        RegWriteD   = 1'b1;
        ResultSrcD  = base[2:0];
        MemWriteD   = base[3];
        JumpD       = base[4];
        BranchD     = base[5];
        ALUSrcD     = base[6];
        ByteAccessD = base[8:7];
        ALUControlD = base[12:9];
        ByteSrcD    = base[15:13];
        PredTakenD  = base[16];
        RD1D        = base;
        RD2D        = ~base;
        PCD         = {base[31:2], 2'b00};
        PCPlus4D    = {base[31:2], 2'b00} + 32'd4;
        ImmExtD     = base ^ 32'h5a5a_5a5a;
        Rs1D        = base[4:0];
        Rs2D        = base[9:5];
        RdD         = base[14:10];
    endtask

    task automatic test_reset();
        StallE = 1'b0; FlushE = 1'b0; reset_n = 1'b0;
        drive_pattern(32'hdead_beef);
        #3;
        checks++;
        if ({payloadE, ValidE, BubbleCnt} !== '0) begin
            failures++;
            $display("FAIL reset_initial got RD1E=%h ValidE=%b cnt=%0d exp all zero", RD1E, ValidE, BubbleCnt);
        end
        #4 reset_n = 1'b1;
        step();
        checks++;
        if (payloadE !== payloadD || ValidE !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_load got RD1E=%h ValidE=%b exp RD1E=%h ValidE=1", RD1E, ValidE, RD1D);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({payloadE, ValidE, BubbleCnt} !== '0) begin
            failures++;
            $display("FAIL reset_midcycle got RD1E=%h PCE=%h ValidE=%b exp all zero", RD1E, PCE, ValidE);
        end
        #1 reset_n = 1'b1;
        expCnt = '0;
    endtask

    task automatic test_load();
        drive_pattern(32'h0000_0000);
        RegWriteD = 1'b1; ALUControlD = 4'b0010; RD1D = 32'h0000_1234; RdD = 5'd5; ValidD = 1'b1;
        step();
        checks++;
        if (RegWriteE !== 1'b1 || ALUControlE !== 4'd2 || RD1E !== 32'h0000_1234 ||
            RdE !== 5'd5 || ValidE !== 1'b1) begin
            failures++;
            $display("FAIL load got RegWriteE=%b ALU=%h RD1E=%h RdE=%0d ValidE=%b exp 1 2 00001234 5 1",
                     RegWriteE, ALUControlE, RD1E, RdE, ValidE);
        end
        drive_pattern(32'h1357_9bdf);
        step();
        checks++;
        if (payloadE !== payloadD) begin
            failures++;
            $display("FAIL load_pattern got RD2E=%h ImmExtE=%h exp RD2E=%h ImmExtE=%h", RD2E, ImmExtE, RD2D, ImmExtD);
        end
    endtask

    task automatic test_stall();
        drive_pattern(32'h0000_0100);
        step();
        StallE = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            PCD = 32'h100 + 32'(4 * i);
            step();
            checks++;
            if (PCE !== 32'h100 || ValidE !== 1'b1 || BubbleCnt !== expCnt) begin
                failures++;
                $display("FAIL stall_hold_%0d got PCE=%h ValidE=%b cnt=%0d exp PCE=00000100 ValidE=1 cnt=%0d",
                         i, PCE, ValidE, BubbleCnt, expCnt);
            end
        end
        StallE = 1'b0;
        step();
        checks++;
        if (PCE !== 32'h10c) begin
            failures++;
            $display("FAIL stall_release got PCE=%h exp 0000010c", PCE);
        end
    endtask

    task automatic test_flush_over_stall();
        drive_pattern(32'hffff_ffff);
        MemWriteD = 1'b1; Rs1D = 5'd7;
        step();
        checks++;
        if (MemWriteE !== 1'b1 || Rs1E !== 5'd7) begin
            failures++;
            $display("FAIL flush_setup got MemWriteE=%b Rs1E=%0d exp 1 7", MemWriteE, Rs1E);
        end
        FlushE = 1'b1; StallE = 1'b1;
        step();
        expCnt = 4'd1;
        checks++;
        if (MemWriteE !== 1'b0 || Rs1E !== 5'd0 || ValidE !== 1'b0 || payloadE !== '0 ||
            BubbleCnt !== expCnt) begin
            failures++;
            $display("FAIL flush_over_stall got MemWriteE=%b Rs1E=%0d ValidE=%b PCE=%h cnt=%0d exp 0 0 0 0 1",
                     MemWriteE, Rs1E, ValidE, PCE, BubbleCnt);
        end
        FlushE = 1'b0; StallE = 1'b0;
    endtask

    task automatic test_valid_passthrough();
        drive_pattern(32'h0246_8ace);
        ValidD = 1'b0; RegWriteD = 1'b1;
        step();
        checks++;
        if (ValidE !== 1'b0 || RegWriteE !== 1'b1 || payloadE !== payloadD || BubbleCnt !== expCnt) begin
            failures++;
            $display("FAIL valid_passthrough got ValidE=%b RegWriteE=%b cnt=%0d exp 0 1 %0d",
                     ValidE, RegWriteE, BubbleCnt, expCnt);
        end
    endtask

    task automatic test_saturation();
        drive_pattern(32'h89ab_cdef);
        FlushE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (expCnt != 4'd15) expCnt = expCnt + 4'd1;
            checks++;
            if (BubbleCnt !== expCnt || payloadE !== '0 || ValidE !== 1'b0) begin
                failures++;
                $display("FAIL saturate_%0d got cnt=%0d ValidE=%b RD1E=%h exp cnt=%0d bubble", i, BubbleCnt,
                         ValidE, RD1E, expCnt);
            end
        end
        FlushE = 1'b0;
        step();
        checks++;
        if (BubbleCnt !== 4'd15 || payloadE !== payloadD) begin
            failures++;
            $display("FAIL saturate_hold got cnt=%0d RD1E=%h exp 15 %h", BubbleCnt, RD1E, RD1D);
        end
    endtask

    task automatic test_reset_during_stall();
        StallE = 1'b1; FlushE = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({payloadE, ValidE, BubbleCnt} !== '0) begin
            failures++;
            $display("FAIL reset_in_stall got RD1E=%h cnt=%0d exp all zero", RD1E, BubbleCnt);
        end
        StallE = 1'b0; FlushE = 1'b0;
        #1 reset_n = 1'b1;
        drive_pattern(32'h7654_3210);
        step();
        checks++;
        if (payloadE !== payloadD || ValidE !== 1'b1 || BubbleCnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_in_stall_release got RD1E=%h ValidE=%b cnt=%0d exp %h 1 0",
                     RD1E, ValidE, BubbleCnt, RD1D);
        end
    endtask

    initial begin
        $display("[TB] id_ex_stage_reg bench start");
        expCnt = '0;
        test_reset();
        test_load();
        test_stall();
        test_flush_over_stall();
        test_valid_passthrough();
        test_saturation();
        test_reset_during_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
Pipeline register between Decode and Execute in the branch-predicted pipelined core. Captures the decode control bundle produced by the control unit, together with the register-file operands, immediates, register indices and branch-prediction metadata. Supports hazard-unit stall (hold) and flush (bubble insertion), and tracks a valid bit. Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
XLEN, 32, datapath width of operands, PC and immediate
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  core clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
StallE  in  1  hold current contents (hazard unit)
FlushE  in  1  load bubble (load-use hazard or branch/jump redirect)
ValidD  in  1  decode-stage instruction valid
RegWriteD  in  1  register write enable
ResultSrcD  in  3  writeback result select
MemWriteD  in  1  data memory write
JumpD  in  1  jump instruction
BranchD  in  1  conditional branch
ALUSrcD  in  1  ALU B operand select
ByteAccessD  in  2  load/store access size
ALUControlD  in  4  ALU operation
ByteSrcD  in  3  load extension select
PredTakenD  in  1  branch predictor taken prediction
RD1D, RD2D  in  XLEN each  register operands
PCD, PCPlus4D, ImmExtD  in  XLEN each  PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  in  5 each  register indices
All of the above with E suffix  out  same width  registered copies
ValidE  out  1  execute-stage instruction valid
BubbleCnt  out  CNT_W  count of flush-inserted bubbles, saturating

Behaviour:
- Reset (reset_n low, asynchronous): every output goes to 0, including ValidE and BubbleCnt. Reset is held while reset_n is low. Release takes effect on the first rising edge with reset_n high.
- Latency: 1 cycle. A value presented on the D inputs at edge N appears on the E outputs after edge N.
- Priority on each rising edge: reset > FlushE > StallE > load.
- Load (FlushE=0, StallE=0): all E outputs take their D inputs. ValidE takes ValidD.
- Stall (StallE=1, FlushE=0): all E outputs, including ValidE, hold their values. BubbleCnt holds.
- Flush (FlushE=1, regardless of StallE): all control outputs go to 0 (RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUSrcE, ByteAccessE, ALUControlE, ByteSrcE, PredTakenE). ValidE goes to 0. Data and index outputs (RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE) also go to 0, so Rs1E/Rs2E=0 cannot trigger forwarding.
- BubbleCnt: increments by 1 on every flush edge. Saturates at 2^CNT_W-1 and never wraps.
- A bubble from a flush is indistinguishable from reset state. It cannot write the register file or memory, or redirect the PC.
- An invalid instruction loaded with ValidD=0 passes its fields through unchanged. Downstream stages qualify side effects with ValidE.
- Reset asserted during a stall or flush: outputs clear immediately. The pending stall or flush has no further effect after release.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive reset_n=0 mid-cycle with nonzero state -> all outputs, ValidE and BubbleCnt read 0 before the next edge. After release with FlushE=StallE=0, the first edge loads the D inputs.
- Load: RegWriteD=1, ALUControlD=4'b0010, RD1D=32'h0000_1234, RdD=5, ValidD=1 -> after 1 edge: RegWriteE=1, ALUControlE=2, RD1E=0x1234, RdE=5, ValidE=1.
- Stall: load PCD=0x100, then raise StallE for 3 cycles while PCD changes to 0x104, 0x108, 0x10C -> PCE stays 0x100 during the stall. After StallE drops, PCE takes the then-current PCD on the next edge.
- Flush over stall: state has MemWriteE=1, Rs1E=7. Assert FlushE=1 and StallE=1 together -> next edge MemWriteE=0, Rs1E=0, ValidE=0, and BubbleCnt goes 0 to 1.
- Counter saturation: CNT_W=4, hold FlushE=1 for 20 cycles -> BubbleCnt reaches 15 and stays at 15.
- Pass-through of ValidD=0: ValidD=0 with RegWriteD=1 -> ValidE=0, RegWriteE=1, BubbleCnt unchanged.
